// File: rtl/ex_mem_if.sv
// Data-memory request/response bundle between the EX/MEM register (master)
// and the data cache (slave).
interface ex_mem_if;
    logic        memdREN;
    logic        memdWEN;
    logic [31:0] memdaddr;
    logic [31:0] memdstore;
    logic        dhit;
    logic [31:0] dload;

    modport master (
        output memdREN, memdWEN, memdaddr, memdstore,
        input  dhit, dload
    );

    modport slave (
        input  memdREN, memdWEN, memdaddr, memdstore,
        output dhit, dload
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with data-memory handshake, sticky halt and optional timeout.
// Define EX_MEM_FWD_EN to add the fwd_valid/fwd_sel/fwd_data forwarding outputs.
module ex_mem_reg #(
    parameter int TIMEOUT = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        exW,
    input  logic        exFLUSH,
    input  logic        excuDRE,
    input  logic        excuDWE,
    input  logic        excuHALT,
    input  logic        exMemToReg,
    input  logic        exWEN,
    input  logic        exJALflag,
    input  logic        exLUIflag,
    input  logic [31:0] exALUout,
    input  logic [31:0] exrdat2,
    input  logic [4:0]  exwsel,
    input  logic [31:0] exiaddr,
    input  logic [31:0] exinstr,
    ex_mem_if.master    dmem,
    output logic        memMemToReg,
    output logic        memWEN,
    output logic        memJALflag,
    output logic        memLUIflag,
    output logic        memHALT,
    output logic [31:0] memALUout,
    output logic [31:0] memdload,
    output logic [31:0] memiaddr,
    output logic [31:0] meminstr,
    output logic [4:0]  memwsel,
    output logic        mem_stall,
    output logic        mem_err
`ifdef EX_MEM_FWD_EN
    ,
    output logic        fwd_valid,
    output logic [4:0]  fwd_sel,
    output logic [31:0] fwd_data
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [31:0] TO_LIM = 32'(TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        dre_q, dwe_q, halt_q, m2r_q, wen_q, jal_q, lui_q;
    logic [31:0] aluout_q, rdat2_q, iaddr_q, instr_q, dload_q;
    logic [4:0]  wsel_q;

    logic        advance_s;
    logic        stall_s;
    logic        load_hit_s;
    logic [31:0] cnt_inc_s;
    logic [31:0] memdload_s;

    assign advance_s = exW & ~stall_s & ~halt_q & ~err_q;
    assign cnt_inc_s = cnt_q + 32'd1;

    // State, wait counter and sticky error register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state: a new instruction overrides everything, else REQ waits on dhit or times out.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (advance_s) begin
            cnt_d = 32'd0;
            if (exFLUSH) begin
                state_d = S_IDLE;
            end else if (excuDRE | excuDWE) begin
                state_d = S_REQ;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (dmem.dhit) begin
                        state_d = S_DONE;
                        cnt_d   = 32'd0;
                    end else if (TIMEOUT != 0) begin
                        if (cnt_inc_s == TO_LIM) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                            cnt_d   = 32'd0;
                        end else begin
                            cnt_d = cnt_inc_s;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                S_IDLE:  state_d = S_IDLE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Request, stall and load-data bypass decoded from the current state.
    always_comb begin
        dmem.memdREN = 1'b0;
        dmem.memdWEN = 1'b0;
        stall_s      = 1'b0;
        load_hit_s   = 1'b0;
        case (state_q)
            S_REQ: begin
                dmem.memdREN = dre_q;
                dmem.memdWEN = dwe_q;
                stall_s      = ~dmem.dhit;
                load_hit_s   = dmem.dhit & dre_q;
            end
            S_IDLE:  stall_s = 1'b0;
            S_DONE:  stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
        if (load_hit_s) begin
            memdload_s = dmem.dload;
        end else begin
            memdload_s = dload_q;
        end
    end

    // Pipeline payload: latched on advance (bubble on flush), load data captured on a read hit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dre_q    <= 1'b0;
            dwe_q    <= 1'b0;
            halt_q   <= 1'b0;
            m2r_q    <= 1'b0;
            wen_q    <= 1'b0;
            jal_q    <= 1'b0;
            lui_q    <= 1'b0;
            aluout_q <= 32'd0;
            rdat2_q  <= 32'd0;
            wsel_q   <= 5'd0;
            iaddr_q  <= 32'd0;
            instr_q  <= 32'd0;
            dload_q  <= 32'd0;
        end else if (advance_s) begin
            dre_q    <= exFLUSH ? 1'b0  : excuDRE;
            dwe_q    <= exFLUSH ? 1'b0  : excuDWE;
            halt_q   <= exFLUSH ? 1'b0  : excuHALT;
            m2r_q    <= exFLUSH ? 1'b0  : exMemToReg;
            wen_q    <= exFLUSH ? 1'b0  : exWEN;
            jal_q    <= exFLUSH ? 1'b0  : exJALflag;
            lui_q    <= exFLUSH ? 1'b0  : exLUIflag;
            aluout_q <= exFLUSH ? 32'd0 : exALUout;
            rdat2_q  <= exFLUSH ? 32'd0 : exrdat2;
            wsel_q   <= exFLUSH ? 5'd0  : exwsel;
            iaddr_q  <= exFLUSH ? 32'd0 : exiaddr;
            instr_q  <= exFLUSH ? 32'd0 : exinstr;
            dload_q  <= 32'd0;
        end else if (load_hit_s) begin
            dload_q  <= dmem.dload;
        end
    end

    assign dmem.memdaddr  = aluout_q;
    assign dmem.memdstore = rdat2_q;
    assign memMemToReg    = m2r_q;
    assign memWEN         = wen_q;
    assign memJALflag     = jal_q;
    assign memLUIflag     = lui_q;
    assign memHALT        = halt_q;
    assign memALUout      = aluout_q;
    assign memdload       = memdload_s;
    assign memiaddr       = iaddr_q;
    assign meminstr       = instr_q;
    assign memwsel        = wsel_q;
    assign mem_stall      = stall_s;
    assign mem_err        = err_q;

`ifdef EX_MEM_FWD_EN
    // A load result is only forwardable once its data has been captured.
    assign fwd_valid = wen_q & (wsel_q != 5'd0) & ~(m2r_q & (state_q != S_DONE));
    assign fwd_sel   = wsel_q;
    assign fwd_data  = m2r_q ? memdload_s : aluout_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed testbench for ex_mem_reg: one instance with the timeout disabled, one with TIMEOUT=4.
module tb_ex_mem_reg;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        exW, exFLUSH, excuDRE, excuDWE, excuHALT, exMemToReg, exWEN, exJALflag, exLUIflag;
    logic [31:0] exALUout, exrdat2, exiaddr, exinstr;
    logic [4:0]  exwsel;

    logic        memMemToReg, memWEN, memJALflag, memLUIflag, memHALT, mem_stall, mem_err;
    logic [31:0] memALUout, memdload, memiaddr, meminstr;
    logic [4:0]  memwsel;

    logic        t_m2r, t_wen, t_jal, t_lui, t_halt, t_stall, t_err;
    logic [31:0] t_alu, t_dload, t_iaddr, t_instr;
    logic [4:0]  t_wsel;

    int total = 0;
    int bad   = 0;

    ex_mem_if mif();
    ex_mem_if mif_t();

    always #5 CLK = ~CLK;

    ex_mem_reg #(.TIMEOUT(0)) u_dut (
        .CLK(CLK), .RST(RST), .exW(exW), .exFLUSH(exFLUSH),
        .excuDRE(excuDRE), .excuDWE(excuDWE), .excuHALT(excuHALT),
        .exMemToReg(exMemToReg), .exWEN(exWEN), .exJALflag(exJALflag), .exLUIflag(exLUIflag),
        .exALUout(exALUout), .exrdat2(exrdat2), .exwsel(exwsel),
        .exiaddr(exiaddr), .exinstr(exinstr), .dmem(mif.master),
        .memMemToReg(memMemToReg), .memWEN(memWEN), .memJALflag(memJALflag),
        .memLUIflag(memLUIflag), .memHALT(memHALT), .memALUout(memALUout),
        .memdload(memdload), .memiaddr(memiaddr), .meminstr(meminstr),
        .memwsel(memwsel), .mem_stall(mem_stall), .mem_err(mem_err)
    );

    ex_mem_reg #(.TIMEOUT(4)) u_dut_to (
        .CLK(CLK), .RST(RST), .exW(exW), .exFLUSH(exFLUSH),
        .excuDRE(excuDRE), .excuDWE(excuDWE), .excuHALT(excuHALT),
        .exMemToReg(exMemToReg), .exWEN(exWEN), .exJALflag(exJALflag), .exLUIflag(exLUIflag),
        .exALUout(exALUout), .exrdat2(exrdat2), .exwsel(exwsel),
        .exiaddr(exiaddr), .exinstr(exinstr), .dmem(mif_t.master),
        .memMemToReg(t_m2r), .memWEN(t_wen), .memJALflag(t_jal),
        .memLUIflag(t_lui), .memHALT(t_halt), .memALUout(t_alu),
        .memdload(t_dload), .memiaddr(t_iaddr), .meminstr(t_instr),
        .memwsel(t_wsel), .mem_stall(t_stall), .mem_err(t_err)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_ex();
        exW = 1'b0; exFLUSH = 1'b0; excuDRE = 1'b0; excuDWE = 1'b0; excuHALT = 1'b0;
        exMemToReg = 1'b0; exWEN = 1'b0; exJALflag = 1'b0; exLUIflag = 1'b0;
        exALUout = 32'd0; exrdat2 = 32'd0; exwsel = 5'd0; exiaddr = 32'd0; exinstr = 32'd0;
    endtask

    task automatic test_reset();
        logic [255:0] all_s;
        clear_ex();
        mif.dhit = 1'b0; mif.dload = 32'd0;
        mif_t.dhit = 1'b0; mif_t.dload = 32'd0;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        tick();
        all_s = {mif.memdREN, mif.memdWEN, mif.memdaddr, mif.memdstore, memMemToReg, memWEN,
                 memJALflag, memLUIflag, memHALT, memALUout, memdload, memiaddr, meminstr,
                 memwsel, mem_stall, mem_err};
        total++;
        if (all_s !== 256'd0) begin
            bad++; $display("FAIL reset_outputs got=%0h exp=0", all_s);
        end
    endtask

    task automatic test_load();
        clear_ex();
        exW = 1'b1; excuDRE = 1'b1; exMemToReg = 1'b1; exWEN = 1'b1;
        exwsel = 5'd3; exALUout = 32'h100;
        tick();
        // upstream keeps presenting a different instruction while stalled
        excuDRE = 1'b0; exALUout = 32'h999; exwsel = 5'd12;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (mif.memdREN !== 1'b1) begin bad++; $display("FAIL load_ren got=%0h exp=1", mif.memdREN); end
            total++;
            if (mif.memdaddr !== 32'h100) begin bad++; $display("FAIL load_addr got=%0h exp=100", mif.memdaddr); end
            total++;
            if (mem_stall !== 1'b1) begin bad++; $display("FAIL load_stall got=%0h exp=1", mem_stall); end
            tick();
        end
        exW = 1'b0;
        mif.dhit = 1'b1; mif.dload = 32'hDEADBEEF;
        #1;
        total++;
        if (mem_stall !== 1'b0) begin bad++; $display("FAIL load_hit_stall got=%0h exp=0", mem_stall); end
        total++;
        if (memdload !== 32'hDEADBEEF) begin bad++; $display("FAIL load_bypass got=%0h exp=deadbeef", memdload); end
        tick();
        mif.dhit = 1'b0; mif.dload = 32'd0;
        #1;
        total++;
        if (memdload !== 32'hDEADBEEF) begin bad++; $display("FAIL load_data got=%0h exp=deadbeef", memdload); end
        total++;
        if ({mif.memdREN, mem_stall} !== 2'b00) begin bad++; $display("FAIL load_done_req got=%0h exp=0", {mif.memdREN, mem_stall}); end
        total++;
        if ({memMemToReg, memWEN, memwsel} !== {1'b1, 1'b1, 5'd3}) begin
            bad++; $display("FAIL load_ctrl got=%0h exp=%0h", {memMemToReg, memWEN, memwsel}, {1'b1, 1'b1, 5'd3});
        end
    endtask

    task automatic test_store_then_alu();
        clear_ex();
        exW = 1'b1; excuDWE = 1'b1; exALUout = 32'h200; exrdat2 = 32'hCAFEF00D;
        tick();
        exW = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({mif.memdWEN, mif.memdREN, mem_stall} !== 3'b101) begin
                bad++; $display("FAIL store_req got=%0b exp=101", {mif.memdWEN, mif.memdREN, mem_stall});
            end
            total++;
            if (mif.memdstore !== 32'hCAFEF00D) begin bad++; $display("FAIL store_data got=%0h exp=cafef00d", mif.memdstore); end
            total++;
            if (memdload !== 32'd0) begin bad++; $display("FAIL store_dload got=%0h exp=0", memdload); end
            tick();
        end
        clear_ex();
        exW = 1'b1; exWEN = 1'b1; exJALflag = 1'b1; exLUIflag = 1'b1; exALUout = 32'h55;
        exwsel = 5'd7; exiaddr = 32'h40; exinstr = 32'h1234_5678;
        mif.dhit = 1'b1; mif.dload = 32'h1111_2222;
        #1;
        total++;
        if (mem_stall !== 1'b0) begin bad++; $display("FAIL store_hit_stall got=%0h exp=0", mem_stall); end
        tick();
        exW = 1'b0; mif.dhit = 1'b0; mif.dload = 32'd0;
        #1;
        total++;
        if (mif.memdWEN !== 1'b0) begin bad++; $display("FAIL alu_wen_mem got=%0h exp=0", mif.memdWEN); end
        total++;
        if ({memALUout, memwsel, memWEN, memJALflag, memLUIflag} !== {32'h55, 5'd7, 3'b111}) begin
            bad++; $display("FAIL alu_latch got=%0h exp=%0h", {memALUout, memwsel, memWEN, memJALflag, memLUIflag}, {32'h55, 5'd7, 3'b111});
        end
        total++;
        if ({memiaddr, meminstr, memdload} !== {32'h40, 32'h1234_5678, 32'd0}) begin
            bad++; $display("FAIL alu_pc_instr got=%0h exp=%0h", {memiaddr, meminstr, memdload}, {32'h40, 32'h1234_5678, 32'd0});
        end
    endtask

    task automatic test_flush();
        clear_ex();
        exW = 1'b1; exFLUSH = 1'b1; excuDWE = 1'b1; exWEN = 1'b1; exALUout = 32'h77;
        tick();
        clear_ex();
        tick();
        total++;
        if ({memWEN, mif.memdWEN, mem_stall} !== 3'b000) begin
            bad++; $display("FAIL flush_ctrl got=%0b exp=000", {memWEN, mif.memdWEN, mem_stall});
        end
        total++;
        if (memALUout !== 32'd0) begin bad++; $display("FAIL flush_data got=%0h exp=0", memALUout); end
    endtask

    task automatic test_reset_midreq();
        clear_ex();
        exW = 1'b1; excuDRE = 1'b1; exALUout = 32'h300; exMemToReg = 1'b1;
        tick();
        exW = 1'b0;
        total++;
        if (mif.memdREN !== 1'b1) begin bad++; $display("FAIL rst_pre_ren got=%0h exp=1", mif.memdREN); end
        RST = 1'b1;
        #1;
        total++;
        if ({mif.memdREN, mem_stall, memMemToReg, memALUout} !== 35'd0) begin
            bad++; $display("FAIL rst_async got=%0h exp=0", {mif.memdREN, mem_stall, memMemToReg, memALUout});
        end
        tick();
        RST = 1'b0;
        tick();
        total++;
        if ({mif.memdREN, mem_stall} !== 2'b00) begin
            bad++; $display("FAIL rst_idle got=%0b exp=00", {mif.memdREN, mem_stall});
        end
    endtask

    task automatic test_halt();
        clear_ex();
        exW = 1'b1; excuHALT = 1'b1; exWEN = 1'b1; exALUout = 32'h400; exwsel = 5'd9;
        tick();
        for (int i = 0; i < 5; i++) begin
            excuHALT = 1'b0; exALUout = 32'h500 + 32'(i); exwsel = 5'(i + 1); exWEN = 1'b0;
            tick();
            total++;
            if ({memHALT, memALUout, memwsel, memWEN, mif.memdREN} !== {1'b1, 32'h400, 5'd9, 1'b1, 1'b0}) begin
                bad++; $display("FAIL halt_hold got=%0h exp=%0h", {memHALT, memALUout, memwsel, memWEN, mif.memdREN}, {1'b1, 32'h400, 5'd9, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_timeout();
        clear_ex();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exW = 1'b1; excuDRE = 1'b1; exALUout = 32'h600;
        tick();
        exW = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({t_err, mif_t.memdREN} !== 2'b01) begin
                bad++; $display("FAIL to_wait cyc=%0d got=%0b exp=01", i, {t_err, mif_t.memdREN});
            end
            tick();
        end
        total++;
        if ({t_err, mif_t.memdREN, t_stall} !== 3'b100) begin
            bad++; $display("FAIL to_err got=%0b exp=100", {t_err, mif_t.memdREN, t_stall});
        end
        total++;
        if ({mem_err, mem_stall, mif.memdREN} !== 3'b011) begin
            bad++; $display("FAIL to_disabled got=%0b exp=011", {mem_err, mem_stall, mif.memdREN});
        end
        exW = 1'b1; excuDRE = 1'b0; exALUout = 32'h700;
        tick();
        tick();
        total++;
        if ({t_err, t_alu} !== {1'b1, 32'h600}) begin
            bad++; $display("FAIL to_blocked got=%0h exp=%0h", {t_err, t_alu}, {1'b1, 32'h600});
        end
        clear_ex();
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_then_alu();
        test_flush();
        test_reset_midreq();
        test_halt();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
